galvo_stepper: RTL and testbench
================================

GALVO_STEPPER -- requirements
Module: galvo_stepper

Interface
REQ-001 SHALL have parameter DAC_W, default 16, width of the galvo DAC codes and of the start/step inputs.
REQ-002 SHALL have ports, clock and reset first:
- iCLK, input, 1: sole clock, 50 MHz.
- iRST, input, 1: reset; synchronous, active-high.
- iTRIGGER, input, 1: galvo change request pulse from the sequencer, ms-long level.
- iSEQ_BUSY, input, 1: sequencer busy; low means no scan in progress.
- iX_START / iY_START, input, DAC_W: first-position DAC codes.
- iX_STEP / iY_STEP, input, DAC_W: signed two's-complement per-position increments.
- iNUM_X / iNUM_Y, input, 8: positions per row / rows.
- iSETTLE_CYCLES, input, 16: galvo settle time in clocks.
- oDAC_X / oDAC_Y, output, DAC_W: registered DAC codes.
- oDAC_LOAD, output, 1: one-cycle DAC latch strobe.
- oGALVO_ACK, output, 1: one-cycle done pulse to the sequencer.
- oX_IDX / oY_IDX, output, 8: index of the current position.
- oBUSY, output, 1: high when the state is not IDLE.
- oOVERRUN, output, 1: sticky flag for a trigger rise seen while not IDLE.

Function
REQ-003 SHALL register iTRIGGER once; a rise is iTRIGGER=1 while the registered copy is 0.
REQ-004 SHALL implement states IDLE, CALC, WRITE, SETTLE and ACK, with these transitions:
- IDLE goes to CALC on a rise.
- CALC goes to WRITE.
- WRITE goes to SETTLE.
- SETTLE goes to ACK when its counter is 0; otherwise it decrements the counter.
- ACK goes to IDLE.
REQ-005 SHALL load the SETTLE counter with iSETTLE_CYCLES on WRITE->SETTLE, so SETTLE lasts iSETTLE_CYCLES+1 cycles.
REQ-006 SHALL assert oDAC_LOAD only in WRITE, and oGALVO_ACK only in ACK.
REQ-007 Latency: with a rise sampled in IDLE at cycle 0, oDAC_LOAD SHALL be high at cycle 2 and oGALVO_ACK at cycle 4+iSETTLE_CYCLES.
REQ-008 SHALL, while in IDLE with iSEQ_BUSY=0, set an internal first flag and clear oX_IDX and oY_IDX.
REQ-009 When the first flag is set, CALC SHALL:
- latch iX_START, iY_START, iX_STEP, iY_STEP, iNUM_X and iNUM_Y;
- output the start codes at index (0,0);
- clear the first flag.
REQ-010 Otherwise CALC SHALL advance X by one position: x += X_STEP and x_idx += 1, using the latched values.
REQ-011 When x_idx is the last in its row (NUM_X-1), CALC SHALL instead:
- clear x_idx and return x per REQ-020;
- set y += Y_STEP and y_idx += 1.
REQ-012 When y_idx is the last row (NUM_Y-1) at a row end, CALC SHALL wrap to index (0,0) at the start codes.
REQ-013 SHALL treat NUM_X=0 or NUM_Y=0 as 1.
REQ-014 SHALL add DAC codes modulo 2^DAC_W, with no saturation.
REQ-015 SHALL change oDAC_X, oDAC_Y, oX_IDX and oY_IDX only on the CALC->WRITE edge.
REQ-016 SHALL ignore a trigger rise outside IDLE for state purposes, and set oOVERRUN.
REQ-017 SHALL clear oOVERRUN only by reset, or by an IDLE cycle with iSEQ_BUSY=0.
REQ-018 SHALL accept a new rise in the cycle after ACK, since the state is then IDLE.

Reset
REQ-019 iRST=1 at a clock edge SHALL, from any state including mid-SETTLE, force the following with no ACK emitted:
- state IDLE;
- oDAC_X=0, oDAC_Y=0, oDAC_LOAD=0, oGALVO_ACK=0;
- oX_IDX=0, oY_IDX=0;
- oBUSY=0, oOVERRUN=0;
- first flag=1, trigger register=0, SETTLE counter=0.

Configuration
REQ-020 The macro GALVO_STEPPER_SERPENTINE_EN SHALL select the row-end X behaviour:
- Defined: a row end holds x unchanged and negates the internal X direction, so odd rows step by -X_STEP. Direction resets to positive at the first position and at the (0,0) wrap.
- Undefined: a row end sets x to the latched X_START, and direction is always positive.

Verification
REQ-021 Case 1: iSEQ_BUSY=0 then 1, X_START=100, Y_START=200, SETTLE=0, one trigger rise -> DAC=(100,200), idx=(0,0), LOAD at cycle 2, ACK at cycle 4, each for exactly one cycle.
REQ-022 Case 2: NUM_X=3, NUM_Y=2, X_STEP=10, Y_STEP=5, seven triggers -> X sequence per macro:
- macro undefined: X 100,110,120,100,110,120,100; Y 200,200,200,205,205,205,200.
- macro defined: X 100,110,120,120,110,100,100.
REQ-023 Case 3: SETTLE=1000 -> ACK exactly 1004 cycles after the rise; a second rise at cycle 500 -> oOVERRUN=1 and no extra ACK.
REQ-024 Case 4: X_START=65530, X_STEP=10 -> second position X=4; X_STEP=-10 (0xFFF6) from X_START=5 -> X=65531.
REQ-025 Case 5: iRST at cycle 300 of SETTLE -> all outputs at reset values on the next cycle and no ACK; the next trigger outputs the start codes.
REQ-026 Case 6: NUM_X=0, NUM_Y=0 -> every trigger outputs the start codes with idx (0,0).

Source files
------------

// File: rtl/galvo_stepper.sv
// Galvo raster stepper: on each trigger rise computes the next (x,y) DAC position, strobes it out,
// waits the settle time, then acknowledges. Define GALVO_STEPPER_SERPENTINE_EN for serpentine rows.
module galvo_stepper #(
  parameter int DAC_W = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iTRIGGER,
  input  logic             iSEQ_BUSY,
  input  logic [DAC_W-1:0] iX_START,
  input  logic [DAC_W-1:0] iY_START,
  input  logic [DAC_W-1:0] iX_STEP,
  input  logic [DAC_W-1:0] iY_STEP,
  input  logic [7:0]       iNUM_X,
  input  logic [7:0]       iNUM_Y,
  input  logic [15:0]      iSETTLE_CYCLES,
  output logic [DAC_W-1:0] oDAC_X,
  output logic [DAC_W-1:0] oDAC_Y,
  output logic             oDAC_LOAD,
  output logic             oGALVO_ACK,
  output logic [7:0]       oX_IDX,
  output logic [7:0]       oY_IDX,
  output logic             oBUSY,
  output logic             oOVERRUN
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_WRITE, S_SETTLE, S_ACK
  } state_t;

  state_t state, state_nxt;

  logic                    trig_q;
  logic                    rise;
  logic [15:0]             settle_cnt;
  logic                    first;
  logic                    x_neg;
  logic [DAC_W-1:0]        x_start_r, y_start_r;
  logic signed [DAC_W-1:0] x_step_r, y_step_r;
  logic [7:0]              num_x_r, num_y_r;
  logic [7:0]              last_x, last_y;

  logic [DAC_W-1:0]        x_nxt, y_nxt;
  logic [7:0]              xi_nxt, yi_nxt;
  logic                    neg_nxt;

  // Codes wrap modulo 2^DAC_W; neg subtracts the step for reverse-direction rows.
  function automatic logic [DAC_W-1:0] wrap_add(input logic [DAC_W-1:0] a,
                                                input logic signed [DAC_W-1:0] d,
                                                input logic neg);
    logic signed [DAC_W-1:0] dd;
    dd = neg ? -d : d;
    return a + dd;
  endfunction

  assign rise   = iTRIGGER & ~trig_q;
  assign last_x = (num_x_r == 8'd0) ? 8'd0 : num_x_r - 8'd1;
  assign last_y = (num_y_r == 8'd0) ? 8'd0 : num_y_r - 8'd1;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rise) state_nxt = S_CALC;
      S_CALC:   state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == 16'd0) state_nxt = S_ACK;
      S_ACK:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oDAC_LOAD  = 1'b0;
    oGALVO_ACK = 1'b0;
    oBUSY      = 1'b0;
    if (state == S_WRITE) oDAC_LOAD = 1'b1;
    if (state == S_ACK)   oGALVO_ACK = 1'b1;
    if (state != S_IDLE)  oBUSY = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST)                    settle_cnt <= 16'd0;
    else if (state == S_WRITE)   settle_cnt <= iSETTLE_CYCLES;
    else if (state == S_SETTLE && settle_cnt != 16'd0)
                                 settle_cnt <= settle_cnt - 16'd1;
  end

  // Next raster position, committed on the CALC->WRITE edge.
  always_comb begin
    x_nxt   = oDAC_X;
    y_nxt   = oDAC_Y;
    xi_nxt  = oX_IDX;
    yi_nxt  = oY_IDX;
    neg_nxt = x_neg;
    if (first) begin
      x_nxt   = iX_START;
      y_nxt   = iY_START;
      xi_nxt  = 8'd0;
      yi_nxt  = 8'd0;
      neg_nxt = 1'b0;
    end else if (oX_IDX >= last_x) begin
      if (oY_IDX >= last_y) begin
        x_nxt   = x_start_r;
        y_nxt   = y_start_r;
        xi_nxt  = 8'd0;
        yi_nxt  = 8'd0;
        neg_nxt = 1'b0;
      end else begin
        xi_nxt = 8'd0;
        yi_nxt = oY_IDX + 8'd1;
        y_nxt  = wrap_add(oDAC_Y, y_step_r, 1'b0);
`ifdef GALVO_STEPPER_SERPENTINE_EN
        x_nxt   = oDAC_X;
        neg_nxt = ~x_neg;
`else
        x_nxt   = x_start_r;
        neg_nxt = 1'b0;
`endif
      end
    end else begin
      xi_nxt = oX_IDX + 8'd1;
      x_nxt  = wrap_add(oDAC_X, x_step_r, x_neg);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      trig_q    <= 1'b0;
      first     <= 1'b1;
      x_neg     <= 1'b0;
      oDAC_X    <= '0;
      oDAC_Y    <= '0;
      oX_IDX    <= 8'd0;
      oY_IDX    <= 8'd0;
      oOVERRUN  <= 1'b0;
      x_start_r <= '0;
      y_start_r <= '0;
      x_step_r  <= '0;
      y_step_r  <= '0;
      num_x_r   <= 8'd0;
      num_y_r   <= 8'd0;
    end else begin
      trig_q <= iTRIGGER;
      if (state == S_IDLE && !iSEQ_BUSY) begin
        first    <= 1'b1;
        oX_IDX   <= 8'd0;
        oY_IDX   <= 8'd0;
        oOVERRUN <= 1'b0;
      end
      if (rise && state != S_IDLE) oOVERRUN <= 1'b1;
      if (state == S_CALC) begin
        oDAC_X <= x_nxt;
        oDAC_Y <= y_nxt;
        oX_IDX <= xi_nxt;
        oY_IDX <= yi_nxt;
        x_neg  <= neg_nxt;
        if (first) begin
          first     <= 1'b0;
          x_start_r <= iX_START;
          y_start_r <= iY_START;
          x_step_r  <= iX_STEP;
          y_step_r  <= iY_STEP;
          num_x_r   <= iNUM_X;
          num_y_r   <= iNUM_Y;
        end
      end
    end
  end

endmodule

// File: tb/tb_galvo_stepper.sv
// Bench for galvo_stepper: raster positions checked against an index-arithmetic model of the scan.
module tb_galvo_stepper;
  localparam int DAC_W = 16;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b1;
  logic             iTRIGGER = 1'b0;
  logic             iSEQ_BUSY = 1'b1;
  logic [DAC_W-1:0] iX_START = '0, iY_START = '0, iX_STEP = '0, iY_STEP = '0;
  logic [7:0]       iNUM_X = 8'd0, iNUM_Y = 8'd0;
  logic [15:0]      iSETTLE_CYCLES = 16'd0;
  logic [DAC_W-1:0] oDAC_X, oDAC_Y;
  logic             oDAC_LOAD, oGALVO_ACK, oBUSY, oOVERRUN;
  logic [7:0]       oX_IDX, oY_IDX;

  galvo_stepper #(.DAC_W(DAC_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iTRIGGER(iTRIGGER), .iSEQ_BUSY(iSEQ_BUSY),
    .iX_START(iX_START), .iY_START(iY_START), .iX_STEP(iX_STEP), .iY_STEP(iY_STEP),
    .iNUM_X(iNUM_X), .iNUM_Y(iNUM_Y), .iSETTLE_CYCLES(iSETTLE_CYCLES),
    .oDAC_X(oDAC_X), .oDAC_Y(oDAC_Y), .oDAC_LOAD(oDAC_LOAD), .oGALVO_ACK(oGALVO_ACK),
    .oX_IDX(oX_IDX), .oY_IDX(oY_IDX), .oBUSY(oBUSY), .oOVERRUN(oOVERRUN)
  );

  always #10 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Scan parameters as the model sees them, plus the count of moves since scan start.
  int m_xs, m_ys, m_xst, m_yst, m_nx, m_ny, m_k;

  function automatic void model_pos(input int k, output logic [15:0] ex, output logic [15:0] ey,
                                    output logic [7:0] exi, output logic [7:0] eyi);
    int nx, ny, p, r, c, xm;
    logic [31:0] tx, ty;
    nx = (m_nx == 0) ? 1 : m_nx;
    ny = (m_ny == 0) ? 1 : m_ny;
    p  = k % (nx * ny);
    r  = p / nx;
    c  = p % nx;
    xm = c;
`ifdef GALVO_STEPPER_SERPENTINE_EN
    if (r % 2 == 1) xm = nx - 1 - c;
`endif
    tx  = m_xs + xm * m_xst;
    ty  = m_ys + r * m_yst;
    ex  = tx[15:0];
    ey  = ty[15:0];
    exi = 8'(c);
    eyi = 8'(r);
  endfunction

  task automatic start_scan(input logic [15:0] xs, input logic [15:0] ys, input logic [15:0] xst,
                            input logic [15:0] yst, input logic [7:0] nx, input logic [7:0] ny);
    @(posedge iCLK); #1;
    iX_START = xs; iY_START = ys; iX_STEP = xst; iY_STEP = yst;
    iNUM_X = nx; iNUM_Y = ny; iSEQ_BUSY = 1'b0;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    iSEQ_BUSY = 1'b1;
    m_xs = int'(xs); m_ys = int'(ys);
    m_xst = int'($signed(xst)); m_yst = int'($signed(yst));
    m_nx = int'(nx); m_ny = int'(ny); m_k = 0;
  endtask

  // Raises the trigger (cycle 0) and records strobe timing until ACK+extra or a cycle budget.
  task automatic do_move(input int settle, input int rise2, input int extra,
                         output int load_cyc, output int ack_cyc, output int n_load, output int n_ack);
    int cyc;
    @(posedge iCLK); #1;
    iSETTLE_CYCLES = 16'(settle);
    iTRIGGER = 1'b1;
    load_cyc = -1; ack_cyc = -1; n_load = 0; n_ack = 0;
    for (cyc = 1; cyc <= settle + 12; cyc++) begin
      @(posedge iCLK); #1;
      if (oDAC_LOAD) begin n_load++; if (load_cyc < 0) load_cyc = cyc; end
      if (oGALVO_ACK) begin n_ack++; if (ack_cyc < 0) ack_cyc = cyc; end
      if (cyc == 3) iTRIGGER = 1'b0;
      if (rise2 > 0 && cyc == rise2) iTRIGGER = 1'b1;
      if (rise2 > 0 && cyc == rise2 + 2) iTRIGGER = 1'b0;
      if (ack_cyc >= 0 && cyc >= ack_cyc + extra) break;
    end
    iTRIGGER = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge iCLK);
    #1;
    n_cmp++;
    if ({oDAC_X, oDAC_Y, oDAC_LOAD, oGALVO_ACK, oX_IDX, oY_IDX, oBUSY, oOVERRUN} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d ld=%b ack=%b xi=%0d yi=%0d busy=%b ovr=%b, expected all 0",
               oDAC_X, oDAC_Y, oDAC_LOAD, oGALVO_ACK, oX_IDX, oY_IDX, oBUSY, oOVERRUN);
    end
    iRST = 1'b0;
  endtask

  task automatic test_single();
    int lc, ac, nl, na;
    start_scan(16'd100, 16'd200, 16'd10, 16'd5, 8'd3, 8'd2);
    do_move(0, 0, 3, lc, ac, nl, na);
    n_cmp++; if (lc !== 2) begin n_fail++; $display("FAIL single_load_cycle: got %0d expected 2", lc); end
    n_cmp++; if (ac !== 4) begin n_fail++; $display("FAIL single_ack_cycle: got %0d expected 4", ac); end
    n_cmp++; if (nl !== 1 || na !== 1) begin n_fail++; $display("FAIL single_pulse_width: load %0d ack %0d expected 1 1", nl, na); end
    n_cmp++;
    if ({oDAC_X, oDAC_Y, oX_IDX, oY_IDX} !== {16'd100, 16'd200, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL single_position: got (%0d,%0d) idx (%0d,%0d) expected (100,200) idx (0,0)", oDAC_X, oDAC_Y, oX_IDX, oY_IDX);
    end
    n_cmp++; if (oBUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", oBUSY); end
    m_k = 1;
  endtask

  task automatic test_sequence();
    int lc, ac, nl, na;
    logic [15:0] ex, ey;
    logic [7:0] exi, eyi;
    int tx[7], ty[7];
`ifdef GALVO_STEPPER_SERPENTINE_EN
    tx = '{100, 110, 120, 120, 110, 100, 100};
`else
    tx = '{100, 110, 120, 100, 110, 120, 100};
`endif
    ty = '{200, 200, 200, 205, 205, 205, 200};
    start_scan(16'd100, 16'd200, 16'd10, 16'd5, 8'd3, 8'd2);
    for (int i = 0; i < 7; i++) begin
      do_move(0, 0, 0, lc, ac, nl, na);
      model_pos(m_k, ex, ey, exi, eyi);
      m_k++;
      n_cmp++;
      if (oDAC_X !== 16'(tx[i]) || oDAC_Y !== 16'(ty[i])) begin
        n_fail++;
        $display("FAIL seq_table[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, oDAC_X, oDAC_Y, tx[i], ty[i]);
      end
      n_cmp++;
      if ({oX_IDX, oY_IDX} !== {exi, eyi}) begin
        n_fail++;
        $display("FAIL seq_idx[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, oX_IDX, oY_IDX, exi, eyi);
      end
      n_cmp++;
      if (lc !== 2 || ac !== 4) begin
        n_fail++;
        $display("FAIL seq_back_to_back_timing[%0d]: load %0d ack %0d expected 2 4", i, lc, ac);
      end
    end
  endtask

  task automatic test_overrun();
    int lc, ac, nl, na;
    start_scan(16'd100, 16'd200, 16'd10, 16'd5, 8'd3, 8'd2);
    do_move(1000, 500, 3, lc, ac, nl, na);
    n_cmp++; if (ac !== 1004) begin n_fail++; $display("FAIL overrun_ack_cycle: got %0d expected 1004", ac); end
    n_cmp++; if (na !== 1 || nl !== 1) begin n_fail++; $display("FAIL overrun_single_ack: ack %0d load %0d expected 1 1", na, nl); end
    n_cmp++; if (oOVERRUN !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", oOVERRUN); end
    n_cmp++;
    if ({oDAC_X, oX_IDX} !== {16'd100, 8'd0}) begin
      n_fail++;
      $display("FAIL overrun_no_advance: got x=%0d xi=%0d expected 100 0", oDAC_X, oX_IDX);
    end
    repeat (5) @(posedge iCLK);
    #1;
    n_cmp++; if (oOVERRUN !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", oOVERRUN); end
    iSEQ_BUSY = 1'b0;
    @(posedge iCLK); #1;
    iSEQ_BUSY = 1'b1;
    n_cmp++; if (oOVERRUN !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", oOVERRUN); end
  endtask

  task automatic test_wrap();
    int lc, ac, nl, na;
    start_scan(16'd65530, 16'd7, 16'd10, 16'd0, 8'd4, 8'd1);
    do_move(0, 0, 1, lc, ac, nl, na);
    do_move(0, 0, 1, lc, ac, nl, na);
    n_cmp++; if (oDAC_X !== 16'd4) begin n_fail++; $display("FAIL wrap_up: got %0d expected 4", oDAC_X); end
    start_scan(16'd5, 16'd7, 16'hFFF6, 16'd0, 8'd4, 8'd1);
    do_move(0, 0, 1, lc, ac, nl, na);
    do_move(0, 0, 1, lc, ac, nl, na);
    n_cmp++; if (oDAC_X !== 16'd65531) begin n_fail++; $display("FAIL wrap_down: got %0d expected 65531", oDAC_X); end
  endtask

  task automatic test_reset_mid_settle();
    int lc, ac, nl, na, acks;
    start_scan(16'd321, 16'd654, 16'd3, 16'd4, 8'd5, 8'd5);
    @(posedge iCLK); #1;
    iSETTLE_CYCLES = 16'd1000;
    iTRIGGER = 1'b1;
    acks = 0;
    for (int cyc = 1; cyc <= 303; cyc++) begin
      @(posedge iCLK); #1;
      if (oGALVO_ACK) acks++;
      if (cyc == 3) iTRIGGER = 1'b0;
      if (cyc == 100) iTRIGGER = 1'b1;
      if (cyc == 102) iTRIGGER = 1'b0;
    end
    n_cmp++; if (oBUSY !== 1'b1 || oOVERRUN !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: busy %b ovr %b expected 1 1", oBUSY, oOVERRUN); end
    iRST = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    n_cmp++;
    if ({oDAC_X, oDAC_Y, oDAC_LOAD, oGALVO_ACK, oX_IDX, oY_IDX, oBUSY, oOVERRUN} !== 52'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got x=%0d y=%0d ld=%b ack=%b xi=%0d yi=%0d busy=%b ovr=%b, expected all 0",
               oDAC_X, oDAC_Y, oDAC_LOAD, oGALVO_ACK, oX_IDX, oY_IDX, oBUSY, oOVERRUN);
    end
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(posedge iCLK); #1;
      if (oGALVO_ACK || oBUSY) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %0d ack/busy cycles expected 0", acks); end
    do_move(2, 0, 1, lc, ac, nl, na);
    n_cmp++;
    if ({oDAC_X, oDAC_Y, oX_IDX, oY_IDX} !== {16'd321, 16'd654, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_restart: got (%0d,%0d) idx (%0d,%0d) expected (321,654) idx (0,0)", oDAC_X, oDAC_Y, oX_IDX, oY_IDX);
    end
  endtask

  task automatic test_zero_dims();
    int lc, ac, nl, na;
    start_scan(16'd1234, 16'd4321, 16'd17, 16'd19, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      do_move(1, 0, 1, lc, ac, nl, na);
      n_cmp++;
      if ({oDAC_X, oDAC_Y, oX_IDX, oY_IDX} !== {16'd1234, 16'd4321, 8'd0, 8'd0}) begin
        n_fail++;
        $display("FAIL zero_dims[%0d]: got (%0d,%0d) idx (%0d,%0d) expected (1234,4321) idx (0,0)", i, oDAC_X, oDAC_Y, oX_IDX, oY_IDX);
      end
    end
  endtask

  task automatic test_random();
    int lc, ac, nl, na, st;
    logic [15:0] ex, ey;
    logic [7:0] exi, eyi;
    for (int s = 0; s < 4; s++) begin
      start_scan(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)));
      for (int i = 0; i < 9; i++) begin
        st = $urandom_range(0, 3);
        do_move(st, 0, $urandom_range(0, 2), lc, ac, nl, na);
        model_pos(m_k, ex, ey, exi, eyi);
        m_k++;
        n_cmp++;
        if ({oDAC_X, oDAC_Y, oX_IDX, oY_IDX} !== {ex, ey, exi, eyi}) begin
          n_fail++;
          $display("FAIL rand[%0d.%0d]: got (%0d,%0d) idx (%0d,%0d) expected (%0d,%0d) idx (%0d,%0d)",
                   s, i, oDAC_X, oDAC_Y, oX_IDX, oY_IDX, ex, ey, exi, eyi);
        end
        n_cmp++;
        if (ac !== 4 + st) begin n_fail++; $display("FAIL rand_ack[%0d.%0d]: got %0d expected %0d", s, i, ac, 4 + st); end
        // Scan parameters are latched at the first position; later input changes must not matter.
        iX_START = 16'($urandom); iX_STEP = 16'($urandom);
        iNUM_X = 8'($urandom); iNUM_Y = 8'($urandom);
      end
    end
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_overrun();
    test_wrap();
    test_reset_mid_settle();
    test_zero_dims();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
